ftdi_word_bridge: RTL and testbench
===================================

# ftdi_word_bridge

Adapts the FT2232H synchronous 245-style byte FIFO to the 32-bit word FIFO interface consumed and produced by the command processor. It packs incoming host bytes into little-endian words for `rx`/`rx_ce`/`rx_en`, and unpacks `tx` words into bytes for the host. The block sits between the FTDI pins and the command processor, in the single system clock domain.

## Interface
Parameters: none.

Ports:
- `clock`  in  1  system clock; FTDI bus sampled and driven on rising edge
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- `ft_data_in`  in  8  FTDI data bus, input side
- `ft_data_out`  out  8  FTDI data bus, output side
- `ft_data_oe`  out  1  1 = FPGA drives the data bus
- `ft_rxf_n`  in  1  0 = host byte available
- `ft_txe_n`  in  1  0 = FTDI can accept a byte
- `ft_oe_n`  out  1  0 = FTDI drives the bus
- `ft_rd_n`  out  1  0 = read strobe
- `ft_wr_n`  out  1  0 = write strobe
- `rx`  out  32  assembled host word
- `rx_ce`  out  1  `rx` holds a valid word
- `rx_en`  in  1  pop request
- `tx`  in  32  word to send to host
- `tx_en`  in  1  push request
- `tx_ce`  out  1  tx holding register empty

## Operation
- **Reset values:**
  - `ft_oe_n`, `ft_rd_n`, `ft_wr_n` = 1.
  - `ft_data_oe`, `rx_ce` = 0; `tx_ce` = 1.
  - `rx` and `ft_data_out` = 0.
  - Byte counters = 0, state = IDLE.
  - Partial words are discarded, including on reset mid-burst.
- **Byte order:** byte 0 is bits 7:0, byte 3 is bits 31:24, in both directions.
- **State machine:** IDLE, RD_OE, RD, WR.
  - **IDLE → WR** when the tx holding register is full and `ft_txe_n`=0. This takes priority over reads.
  - **Otherwise IDLE → RD_OE** when `ft_rxf_n`=0 and the rx holding register is empty.
  - **RD_OE → RD** unconditionally.
  - **RD → IDLE** when the 4th byte of a word is accepted, or when `ft_rxf_n`=1.
  - **WR → IDLE** when the 4th byte is accepted, or when `ft_txe_n`=1.
  - IDLE always lasts at least one cycle between bursts, giving bus turnaround.
- **Output drive per state:**
  - `ft_oe_n`=0 in RD_OE and RD.
  - `ft_rd_n`=0 in RD only.
  - `ft_wr_n`=0 and `ft_data_oe`=1 in WR only.
  - All strobes and drives are registered.
- **Read accept:**
  - A byte is accepted on an edge where `ft_rd_n`=0 and `ft_rxf_n`=0.
  - It is stored at the byte index given by a 2-bit counter, which then increments.
  - A partial count survives an exit on `ft_rxf_n`=1 and resumes on the next burst.
- **Read handoff:**
  - Acceptance of byte 3 loads the holding register; `rx_ce`=1 from the next cycle.
  - `rx_en`=1 with `rx_ce`=1 pops the word; `rx_ce`=0 the next cycle.
  - `rx_en` while `rx_ce`=0 is ignored, since the command processor asserts it speculatively.
- **Write load:**
  - `tx_en`=1 with `tx_ce`=1 loads `tx` into the holding register; `tx_ce`=0 the next cycle.
  - `tx_en` while `tx_ce`=0 is ignored; the word is lost, which is a caller error.
- **Write accept:**
  - `ft_data_out` = the byte at the tx byte index.
  - A byte is accepted on an edge where `ft_wr_n`=0 and `ft_txe_n`=0; the index increments.
  - After byte 3 is accepted, the holding register is empty and `tx_ce`=1 on the next cycle.
  - A partial index survives an exit on `ft_txe_n`=1.

## Timing
- **Host-to-rx latency:**
  - The RD_OE → RD transition takes 2 cycles.
  - Four bytes at 1 per cycle then follow.
  - `rx_ce` rises 1 cycle after the 4th byte.
  - Minimum from `ft_rxf_n` falling in IDLE to `rx_ce`: 7 cycles.
- **tx_en-to-first-byte:**
  - Minimum 2 cycles: holding load, then WR entry.
  - WR keeps `ft_wr_n`=0 for up to 4 consecutive cycles.
- **Throughput:** one byte per cycle within a burst, one word per burst.
- **Simultaneous events:**
  - Pop and reload of rx cannot coincide, because RD is entered only when the holding register is empty.
  - `tx_en` during WR cannot occur, because `tx_ce`=0.

## Structure
- **Shared package `ftdi_pkg`:**
  - State encoding (2 bits).
  - Byte-index width (2).
  - `FT_BYTES_PER_WORD` = 4.
- **Sub-module `ftdi_rx_packer`:** byte-to-word assembly, rx holding register and the `rx_ce`/`rx_en` handshake.
- **Top level:** the FSM and the tx unpacker stay inline.

## Test plan
- **Basic read:** reset; `ft_rxf_n`=0 supplying 0x11,0x22,0x33,0x44 → `rx`=0x44332211, `rx_ce`=1 at cycle 7; `rx_en` pulse → `rx_ce`=0.
- **Read stall:**
  - `ft_rxf_n` rises after 2 bytes (0xAA,0xBB), then later supplies 0xCC,0xDD.
  - Required: `rx`=0xDDCCBBAA.
  - The RD_OE → RD sequence is repeated on resumption.
- **Backpressure:**
  - Two words queued at the host, `rx_en` held 0.
  - Required: after the first word, `ft_oe_n`/`ft_rd_n` stay 1 until the pop, then the second word is read.
- **Basic write:** `tx`=0xDEADBEEF with `tx_en` → bytes EF,AD,BE,DE on `ft_data_out` with `ft_wr_n`=0; `tx_ce`=1 afterwards.
- **Write priority:**
  - Pending rx data plus a pending tx word in IDLE → WR is entered first.
  - `ft_data_oe` and `ft_oe_n`=0 are never both asserted.
  - IDLE appears between WR and RD_OE.
- **Reset mid-burst:** reset after 2 write bytes → strobes return to 1, `tx_ce`=1, and no further bytes are driven.

Source files
------------

// File: rtl/ftdi_pkg.sv
// Shared definitions for the FT2232H synchronous-FIFO word bridge:
// FSM encoding, byte-index width and word geometry.
package ftdi_pkg;

  localparam int FT_BYTES_PER_WORD = 4;
  localparam int FT_IDX_W          = 2;

  typedef logic [FT_IDX_W-1:0] byte_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_OE = 2'd1,
    ST_RD    = 2'd2,
    ST_WR    = 2'd3
  } ft_state_e;

  function automatic logic is_last_byte(input byte_idx_t idx);
    return idx == byte_idx_t'(FT_BYTES_PER_WORD - 1);
  endfunction

endpackage

// File: rtl/ftdi_word_bridge_if.sv
// FTDI pin bundle plus the 32-bit word FIFO handshake toward the command processor.
// slave = the bridge; master = the FTDI chip and command processor around it.
interface ftdi_word_bridge_if;

  logic [7:0]  ft_data_in;
  logic [7:0]  ft_data_out;
  logic        ft_data_oe;
  logic        ft_rxf_n;
  logic        ft_txe_n;
  logic        ft_oe_n;
  logic        ft_rd_n;
  logic        ft_wr_n;
  logic [31:0] rx;
  logic        rx_ce;
  logic        rx_en;
  logic [31:0] tx;
  logic        tx_en;
  logic        tx_ce;

  modport slave (
    input  ft_data_in, ft_rxf_n, ft_txe_n, rx_en, tx, tx_en,
    output ft_data_out, ft_data_oe, ft_oe_n, ft_rd_n, ft_wr_n, rx, rx_ce, tx_ce
  );

  modport master (
    output ft_data_in, ft_rxf_n, ft_txe_n, rx_en, tx, tx_en,
    input  ft_data_out, ft_data_oe, ft_oe_n, ft_rd_n, ft_wr_n, rx, rx_ce, tx_ce
  );

endinterface

// File: rtl/ftdi_rx_packer.sv
// Packs accepted host bytes into little-endian words and holds one word
// for the command processor behind the rx_ce / rx_en handshake.
module ftdi_rx_packer
  import ftdi_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_accept,
  input  logic [7:0]  i_data,
  input  logic        i_pop,
  output byte_idx_t   o_idx,
  output logic [31:0] o_rx,
  output logic        o_rx_ce
);

  byte_idx_t   r_idx;
  logic [23:0] r_asm;
  logic [31:0] r_rx;
  logic        r_rx_ce;

  // NOTE: non-blocking assignments for all state so every register samples
  // pre-edge values; the reset branch clears the small assembly buffer too,
  // which is cheap here and makes mid-burst reset discard the partial word.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx   <= '0;
      r_asm   <= '0;
      r_rx    <= '0;
      r_rx_ce <= 1'b0;
    end else begin
      if (i_pop && r_rx_ce)
        r_rx_ce <= 1'b0;
      if (i_accept) begin
        r_idx <= r_idx + 1'b1;
        case (r_idx)
          2'd0:    r_asm[7:0]   <= i_data;
          2'd1:    r_asm[15:8]  <= i_data;
          2'd2:    r_asm[23:16] <= i_data;
          default: begin
            r_rx    <= {i_data, r_asm};
            r_rx_ce <= 1'b1;
          end
        endcase
      end
    end
  end

  assign o_idx   = r_idx;
  assign o_rx    = r_rx;
  assign o_rx_ce = r_rx_ce;

endmodule

// File: rtl/ftdi_word_bridge.sv
// FT2232H sync-245 byte FIFO to 32-bit word FIFO bridge: bus-ownership FSM,
// tx word unpacker and the rx packer instance.
module ftdi_word_bridge
  import ftdi_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  ftdi_word_bridge_if.slave   bus
);

  ft_state_e   r_state, w_next;
  logic        r_oe_n, r_rd_n, r_wr_n, r_data_oe;
  logic        w_oe_n, w_rd_n, w_wr_n, w_data_oe;
  logic [31:0] r_tx;
  logic        r_tx_ce;
  byte_idx_t   r_tx_idx;
  byte_idx_t   w_rx_idx;
  logic        w_rx_ce;
  logic        w_rd_accept, w_wr_accept;
  logic [7:0]  w_tx_byte;

  // The strobes are registered, so an accept means the strobe was already low at this edge.
  assign w_rd_accept = !r_rd_n && !bus.ft_rxf_n;
  assign w_wr_accept = !r_wr_n && !bus.ft_txe_n;

  ftdi_rx_packer u_rx_packer (
    .clock    (clock),
    .reset    (reset),
    .i_accept (w_rd_accept),
    .i_data   (bus.ft_data_in),
    .i_pop    (bus.rx_en),
    .o_idx    (w_rx_idx),
    .o_rx     (bus.rx),
    .o_rx_ce  (w_rx_ce)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!r_tx_ce && !bus.ft_txe_n)
          w_next = ST_WR;
        else if (!bus.ft_rxf_n && !w_rx_ce)
          w_next = ST_RD_OE;
      end
      ST_RD_OE: w_next = ST_RD;
      ST_RD: begin
        if (bus.ft_rxf_n || (w_rd_accept && is_last_byte(w_rx_idx)))
          w_next = ST_IDLE;
      end
      ST_WR: begin
        if (bus.ft_txe_n || (w_wr_accept && is_last_byte(r_tx_idx)))
          w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase

    w_oe_n    = !(w_next == ST_RD_OE || w_next == ST_RD);
    w_rd_n    = !(w_next == ST_RD);
    w_wr_n    = !(w_next == ST_WR);
    w_data_oe =  (w_next == ST_WR);
  end

  always_comb begin
    w_tx_byte = r_tx[7:0];
    case (r_tx_idx)
      2'd1:    w_tx_byte = r_tx[15:8];
      2'd2:    w_tx_byte = r_tx[23:16];
      2'd3:    w_tx_byte = r_tx[31:24];
      default: w_tx_byte = r_tx[7:0];
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_oe_n    <= 1'b1;
      r_rd_n    <= 1'b1;
      r_wr_n    <= 1'b1;
      r_data_oe <= 1'b0;
      r_tx      <= '0;
      r_tx_ce   <= 1'b1;
      r_tx_idx  <= '0;
    end else begin
      r_state   <= w_next;
      r_oe_n    <= w_oe_n;
      r_rd_n    <= w_rd_n;
      r_wr_n    <= w_wr_n;
      r_data_oe <= w_data_oe;
      if (bus.tx_en && r_tx_ce) begin
        r_tx    <= bus.tx;
        r_tx_ce <= 1'b0;
      end
      if (w_wr_accept) begin
        r_tx_idx <= r_tx_idx + 1'b1;
        if (is_last_byte(r_tx_idx))
          r_tx_ce <= 1'b1;
      end
    end
  end

  assign bus.ft_oe_n     = r_oe_n;
  assign bus.ft_rd_n     = r_rd_n;
  assign bus.ft_wr_n     = r_wr_n;
  assign bus.ft_data_oe  = r_data_oe;
  assign bus.ft_data_out = w_tx_byte;
  assign bus.rx_ce       = w_rx_ce;
  assign bus.tx_ce       = r_tx_ce;

endmodule

// File: tb/tb_ftdi_word_bridge.sv
// Scoreboard bench for ftdi_word_bridge: a host model feeds/collects FTDI bytes,
// stimulus queues expected words/bytes, a negedge monitor compares.
module tb_ftdi_word_bridge;

  typedef enum int {PH_IDLE, PH_RDOE, PH_RD, PH_WR} phase_e;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ftdi_word_bridge_if bus ();

  ftdi_word_bridge dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0]  host_q[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_rx[$];
  bit          host_hold = 1'b0;
  int          n_checks  = 0;
  int          n_pass    = 0;
  int          n_rdoe    = 0;
  phase_e      prev_phase = PH_IDLE;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
  endtask

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    check(act === req, name, act, req);
  endtask

  // Host model and monitor: inputs change and outputs are sampled on the falling edge.
  bit acc_pending = 1'b0;
  always @(negedge clock) begin
    phase_e ph;
    logic [7:0]  eb;
    logic [31:0] ew;
    if (acc_pending) void'(host_q.pop_front());
    bus.ft_rxf_n   = (host_q.size() == 0) || host_hold;
    bus.ft_data_in = (host_q.size() != 0) ? host_q[0] : 8'h00;
    acc_pending    = !reset && !bus.ft_rd_n && !bus.ft_rxf_n;

    if (!reset) begin
      if (!bus.ft_wr_n && !bus.ft_txe_n) begin
        if (exp_tx.size() == 0)
          check(1'b0, "tx_byte_unexpected", 32'(bus.ft_data_out), 32'h0);
        else begin
          eb = exp_tx.pop_front();
          expect_eq("tx_byte", 32'(bus.ft_data_out), 32'(eb));
        end
        expect_eq("tx_data_oe", 32'(bus.ft_data_oe), 32'd1);
      end
      if (bus.rx_en && bus.rx_ce) begin
        if (exp_rx.size() == 0)
          check(1'b0, "rx_word_unexpected", bus.rx, 32'h0);
        else begin
          ew = exp_rx.pop_front();
          expect_eq("rx_word", bus.rx, ew);
        end
      end
      check(!(bus.ft_data_oe && !bus.ft_oe_n), "bus_contention",
            32'({bus.ft_data_oe, bus.ft_oe_n}), 32'b01);

      if (!bus.ft_wr_n)                    ph = PH_WR;
      else if (!bus.ft_rd_n)               ph = PH_RD;
      else if (!bus.ft_oe_n)               ph = PH_RDOE;
      else                                 ph = PH_IDLE;
      if (ph == PH_RDOE && prev_phase != PH_RDOE) begin
        n_rdoe++;
        expect_eq("turnaround_before_rdoe", 32'(prev_phase), 32'(PH_IDLE));
      end
      prev_phase = ph;
    end else begin
      prev_phase = PH_IDLE;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_rx_ce(input string name);
    int k = 0;
    while (bus.rx_ce !== 1'b1 && k < 50) begin tick(1); k++; end
    expect_eq(name, 32'(bus.rx_ce), 32'd1);
  endtask

  task automatic wait_tx_ce(input string name);
    int k = 0;
    while (bus.tx_ce !== 1'b1 && k < 50) begin tick(1); k++; end
    expect_eq(name, 32'(bus.tx_ce), 32'd1);
  endtask

  task automatic pop_rx(input string name);
    wait_rx_ce(name);
    bus.rx_en = 1'b1;
    tick(1);
    bus.rx_en = 1'b0;
    expect_eq({name, "_rx_ce_after_pop"}, 32'(bus.rx_ce), 32'd0);
  endtask

  task automatic host_push(input logic [7:0] b);
    host_q.push_back(b);
  endtask

  task automatic push_rx_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) host_q.push_back(w[8*i +: 8]);
    exp_rx.push_back(w);
  endtask

  // Loads a tx word; only the first n_exp bytes are expected to reach the host.
  task automatic load_tx(input logic [31:0] w, input int n_exp);
    for (int i = 0; i < n_exp; i++) exp_tx.push_back(w[8*i +: 8]);
    bus.tx    = w;
    bus.tx_en = 1'b1;
    tick(1);
    bus.tx_en = 1'b0;
    expect_eq("tx_ce_after_load", 32'(bus.tx_ce), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdoe0;
    bus.rx_en    = 1'b0;
    bus.tx_en    = 1'b0;
    bus.tx       = 32'h0;
    bus.ft_txe_n = 1'b1;
    reset        = 1'b1;
    tick(3);

    expect_eq("rst_strobes", 32'({bus.ft_oe_n, bus.ft_rd_n, bus.ft_wr_n}), 32'b111);
    expect_eq("rst_data_oe", 32'(bus.ft_data_oe), 32'd0);
    expect_eq("rst_rx_ce",   32'(bus.rx_ce), 32'd0);
    expect_eq("rst_tx_ce",   32'(bus.tx_ce), 32'd1);
    expect_eq("rst_rx",      bus.rx, 32'h0);
    expect_eq("rst_data_out", 32'(bus.ft_data_out), 32'h0);
    reset = 1'b0;
    tick(2);

    // Basic read with exact latency: rx_ce first seen in cycle 7.
    push_rx_word(32'h44332211);
    tick(5);
    expect_eq("rx_ce_before_cycle7", 32'(bus.rx_ce), 32'd0);
    tick(1);
    expect_eq("rx_ce_cycle7", 32'(bus.rx_ce), 32'd1);
    pop_rx("basic_read");
    tick(3);

    // Read stall after two bytes, resumed later through RD_OE again.
    rdoe0 = n_rdoe;
    exp_rx.push_back(32'hDDCCBBAA);
    host_push(8'hAA);
    host_push(8'hBB);
    tick(12);
    expect_eq("rx_ce_partial", 32'(bus.rx_ce), 32'd0);
    expect_eq("stall_bus_idle", 32'({bus.ft_oe_n, bus.ft_rd_n}), 32'b11);
    host_push(8'hCC);
    host_push(8'hDD);
    pop_rx("stall_read");
    expect_eq("stall_rdoe_count", 32'(n_rdoe - rdoe0), 32'd2);
    tick(3);

    // Backpressure: second word waits until the first is popped.
    push_rx_word(32'h87654321);
    push_rx_word(32'h0FEDCBA9);
    wait_rx_ce("bp_first");
    for (int i = 0; i < 8; i++) begin
      tick(1);
      expect_eq("bp_bus_idle", 32'({bus.ft_oe_n, bus.ft_rd_n}), 32'b11);
    end
    expect_eq("bp_host_bytes_left", 32'(host_q.size()), 32'd4);
    pop_rx("bp_pop1");
    pop_rx("bp_pop2");
    tick(3);

    // Basic write.
    bus.ft_txe_n = 1'b0;
    load_tx(32'hDEADBEEF, 4);
    wait_tx_ce("wr_tx_ce_done");
    expect_eq("wr_all_bytes", 32'(exp_tx.size()), 32'd0);
    tick(1);
    expect_eq("wr_strobe_released", 32'(bus.ft_wr_n), 32'd1);
    tick(2);

    // Write priority over a simultaneously pending read.
    bus.ft_txe_n = 1'b1;
    host_hold    = 1'b1;
    load_tx(32'hCAFEF00D, 4);
    push_rx_word(32'h5A6B7C8D);
    tick(3);
    expect_eq("prio_idle_held", 32'({bus.ft_oe_n, bus.ft_wr_n}), 32'b11);
    bus.ft_txe_n = 1'b0;
    host_hold    = 1'b0;
    tick(1);
    expect_eq("prio_wr_first", 32'({bus.ft_wr_n, bus.ft_oe_n}), 32'b01);
    wait_tx_ce("prio_tx_done");
    pop_rx("prio_read");
    tick(3);

    // Reset after two write bytes.
    bus.ft_txe_n = 1'b1;
    load_tx(32'h01020304, 2);
    bus.ft_txe_n = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    expect_eq("mid_rst_strobes", 32'({bus.ft_oe_n, bus.ft_rd_n, bus.ft_wr_n}), 32'b111);
    expect_eq("mid_rst_data_oe", 32'(bus.ft_data_oe), 32'd0);
    expect_eq("mid_rst_tx_ce", 32'(bus.tx_ce), 32'd1);
    expect_eq("mid_rst_two_bytes", 32'(exp_tx.size()), 32'd0);
    tick(10);
    expect_eq("mid_rst_no_wr", 32'(bus.ft_wr_n), 32'd1);

    expect_eq("end_rx_queue_empty", 32'(exp_rx.size()), 32'd0);
    expect_eq("end_host_queue_empty", 32'(host_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
